// File: rtl/bridge_1xn_if.sv
// rtl/bridge_1xn_if.sv - CPU data-SRAM-style master bus bundle for bridge_1xn
//
// Signals:
//   cpu_data_en     access request
//   cpu_data_wen    byte write enables, 0 means read
//   cpu_data_addr   byte address
//   cpu_data_wdata  write data
//   cpu_data_rdata  read data returned by the bridge
// Modports:
//   master  CPU side (drives the request, receives read data)
//   slave   bridge side (receives the request, drives read data)
interface bridge_1xn_if #(
    parameter int XLEN = 32
);
    logic            cpu_data_en;
    logic [3:0]      cpu_data_wen;
    logic [XLEN-1:0] cpu_data_addr;
    logic [XLEN-1:0] cpu_data_wdata;
    logic [XLEN-1:0] cpu_data_rdata;

    modport master (
        output cpu_data_en,
        output cpu_data_wen,
        output cpu_data_addr,
        output cpu_data_wdata,
        input  cpu_data_rdata
    );

    modport slave (
        input  cpu_data_en,
        input  cpu_data_wen,
        input  cpu_data_addr,
        input  cpu_data_wdata,
        output cpu_data_rdata
    );
endinterface

// File: rtl/bridge_1xn.sv
// rtl/bridge_1xn.sv - one CPU data master to NUM_SLAVES slaves, base/mask decode, read latency tracking
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   cpu        bridge_1xn_if.slave, CPU data port (en/wen/addr/wdata in, rdata out)
//   slv_en     one-hot slave enable
//   slv_wen    per-slave byte enables, slice i at [i*4 +: 4]
//   slv_addr   per-slave address, full CPU address broadcast
//   slv_wdata  per-slave write data, broadcast
//   slv_rdata  per-slave read data, slice i at [i*XLEN +: XLEN]
// Optional feature, macro BRIDGE_DECERR_EN:
//   err_valid  one-cycle pulse the cycle after an unmapped enabled access
//   err_addr   address of the most recent unmapped access
//   err_cnt    saturating count of unmapped accesses
//   unmapped reads return 32'hdead_beef instead of 0
module bridge_1xn #(
    parameter int                         XLEN       = 32,
    parameter int                         NUM_SLAVES = 2,
    parameter logic [NUM_SLAVES*XLEN-1:0] SLV_BASE   = {32'h1faf_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*XLEN-1:0] SLV_MASK   = {32'hffff_0000, 32'h0000_0000},
    parameter int                         RD_LATENCY = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    bridge_1xn_if.slave                cpu,
    output logic [NUM_SLAVES-1:0]      slv_en,
    output logic [4*NUM_SLAVES-1:0]    slv_wen,
    output logic [XLEN*NUM_SLAVES-1:0] slv_addr,
    output logic [XLEN*NUM_SLAVES-1:0] slv_wdata,
    input  logic [XLEN*NUM_SLAVES-1:0] slv_rdata
`ifdef BRIDGE_DECERR_EN
    ,
    output logic                       err_valid,
    output logic [XLEN-1:0]            err_addr,
    output logic [7:0]                 err_cnt
`endif
);
    localparam int NS   = NUM_SLAVES;
    localparam int LAST = RD_LATENCY - 1;

    logic [NS-1:0] hit;
    logic [NS-1:0] sel;
    logic          found;
    logic          rd_issue;

    // One entry per cycle of read latency; the last entry steers rdata.
    logic          pipe_vld [RD_LATENCY];
    logic [NS-1:0] pipe_sel [RD_LATENCY];
`ifdef BRIDGE_DECERR_EN
    logic          pipe_err [RD_LATENCY];
    logic          unmapped_acc;
`endif

    always_comb begin
        hit = '0;
        for (int i = 0; i < NS; i++) begin
            hit[i] = ((cpu.cpu_data_addr & SLV_MASK[i*XLEN +: XLEN]) ==
                      (SLV_BASE[i*XLEN +: XLEN] & SLV_MASK[i*XLEN +: XLEN]));
        end
    end

    // Lowest index wins so overlapping windows resolve by priority.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < NS; i++) begin
            if (hit[i] && !found) begin
                sel[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end

    assign rd_issue = cpu.cpu_data_en && (cpu.cpu_data_wen == 4'b0000);

    always_comb begin
        slv_en    = '0;
        slv_wen   = '0;
        slv_addr  = '0;
        slv_wdata = '0;
        for (int i = 0; i < NS; i++) begin
            slv_en[i]              = cpu.cpu_data_en && sel[i] && !reset;
            slv_wen[i*4 +: 4]      = (sel[i] && !reset) ? cpu.cpu_data_wen : 4'b0000;
            slv_addr[i*XLEN +: XLEN]  = cpu.cpu_data_addr;
            slv_wdata[i*XLEN +: XLEN] = cpu.cpu_data_wdata;
        end
    end

    // Unmapped reads enter as vld with sel == 0, which naturally yields 0 data.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < RD_LATENCY; k++) begin
                pipe_vld[k] <= 1'b0;
                pipe_sel[k] <= '0;
`ifdef BRIDGE_DECERR_EN
                pipe_err[k] <= 1'b0;
`endif
            end
        end else begin
            pipe_vld[0] <= rd_issue;
            pipe_sel[0] <= sel;
`ifdef BRIDGE_DECERR_EN
            pipe_err[0] <= rd_issue && !found;
`endif
            for (int k = 1; k < RD_LATENCY; k++) begin
                pipe_vld[k] <= pipe_vld[k-1];
                pipe_sel[k] <= pipe_sel[k-1];
`ifdef BRIDGE_DECERR_EN
                pipe_err[k] <= pipe_err[k-1];
`endif
            end
        end
    end

    // Gated by reset so a read caught in the last stage never leaks out.
    always_comb begin
        cpu.cpu_data_rdata = '0;
        if (pipe_vld[LAST] && !reset) begin
            for (int i = 0; i < NS; i++) begin
                if (pipe_sel[LAST][i]) begin
                    cpu.cpu_data_rdata = cpu.cpu_data_rdata | slv_rdata[i*XLEN +: XLEN];
                end
            end
`ifdef BRIDGE_DECERR_EN
            if (pipe_err[LAST]) begin
                cpu.cpu_data_rdata = XLEN'(32'hdead_beef);
            end
`endif
        end
    end

`ifdef BRIDGE_DECERR_EN
    assign unmapped_acc = cpu.cpu_data_en && !found;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_valid <= 1'b0;
            err_addr  <= '0;
            err_cnt   <= 8'h00;
        end else begin
            err_valid <= unmapped_acc;
            if (unmapped_acc) begin
                err_addr <= cpu.cpu_data_addr;
                if (err_cnt != 8'hff) begin
                    err_cnt <= err_cnt + 8'h01;
                end
            end
        end
    end
`endif
endmodule

// File: tb/tb_bridge_1xn.sv
// tb/tb_bridge_1xn.sv - randomized scoreboard bench for bridge_1xn (3 slaves, read latency 2)
module tb_bridge_1xn;
    localparam int NS     = 3;
    localparam int L      = 2;
    localparam int CYCLES = 3000;
    localparam int DIRECT = 300;

    localparam logic [31:0] BASE [NS] = '{32'h0000_0000, 32'h1faf_0000, 32'h1fa0_0000};
    localparam logic [31:0] MASK [NS] = '{32'hffff_0000, 32'hffff_0000, 32'hfff0_0000};

`ifdef BRIDGE_DECERR_EN
    localparam logic [31:0] UNMAPPED_RD = 32'hdead_beef;
`else
    localparam logic [31:0] UNMAPPED_RD = 32'h0000_0000;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [NS-1:0]     slv_en;
    logic [4*NS-1:0]   slv_wen;
    logic [32*NS-1:0]  slv_addr;
    logic [32*NS-1:0]  slv_wdata;
    logic [32*NS-1:0]  slv_rdata;
`ifdef BRIDGE_DECERR_EN
    logic              err_valid;
    logic [31:0]       err_addr;
    logic [7:0]        err_cnt;
`endif

    bridge_1xn_if #(.XLEN(32)) bif ();

    bridge_1xn #(
        .XLEN       (32),
        .NUM_SLAVES (NS),
        .SLV_BASE   ({32'h1fa0_0000, 32'h1faf_0000, 32'h0000_0000}),
        .SLV_MASK   ({32'hfff0_0000, 32'hffff_0000, 32'hffff_0000}),
        .RD_LATENCY (L)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu       (bif.slave),
        .slv_en    (slv_en),
        .slv_wen   (slv_wen),
        .slv_addr  (slv_addr),
        .slv_wdata (slv_wdata),
        .slv_rdata (slv_rdata)
`ifdef BRIDGE_DECERR_EN
        ,
        .err_valid (err_valid),
        .err_addr  (err_addr),
        .err_cnt   (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NS-1:0]   en;
        logic [4*NS-1:0] wen;
        logic [31:0]     addr;
        logic [31:0]     wdata;
    } req_t;

    typedef struct {
        logic        valid;
        logic [31:0] addr;
        logic [7:0]  cnt;
    } err_t;

    req_t        req_q [$];
    logic [31:0] rd_q  [$];
    err_t        err_q [$];

    int total = 0;
    int bad   = 0;
    logic running = 1'b0;

    int          m_cnt  = 0;
    logic [31:0] m_addr = 32'h0;

    function automatic int model_sel(input logic [31:0] a);
        for (int i = 0; i < NS; i++) begin
            if ((a & MASK[i]) == (BASE[i] & MASK[i])) return i;
        end
        return -1;
    endfunction

    function automatic logic [31:0] slave_data(input int i, input logic [31:0] a);
        return a ^ (32'(i + 1) * 32'h1111_1111);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Slave model: each slave answers a read exactly L cycles later, otherwise drives junk.
    logic        sv_vld  [NS][L];
    logic [31:0] sv_addr [NS][L];
    logic [31:0] junk    [NS];

    always @(posedge clk) begin
        for (int i = 0; i < NS; i++) begin
            for (int k = L - 1; k > 0; k--) begin
                sv_vld[i][k]  <= sv_vld[i][k-1];
                sv_addr[i][k] <= sv_addr[i][k-1];
            end
            sv_vld[i][0]  <= slv_en[i] && (slv_wen[i*4 +: 4] == 4'b0000);
            sv_addr[i][0] <= slv_addr[i*32 +: 32];
            junk[i]       <= $urandom;
        end
    end

    always_comb begin
        slv_rdata = '0;
        for (int i = 0; i < NS; i++) begin
            slv_rdata[i*32 +: 32] = sv_vld[i][L-1] ? slave_data(i, sv_addr[i][L-1]) : junk[i];
        end
    end

    function automatic logic [31:0] pick_addr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 7))
            0: return {16'h0000, r[15:2], 2'b00};
            1: return 32'h0000_fffc;
            2: return 32'h0001_0000;
            3: return {16'h1faf, r[15:2], 2'b00};
            4: return 32'h1faf_fffc;
            5: return 32'h1fb0_0000;
            6: return {12'h1fa, r[19:2], 2'b00};
            default: return r;
        endcase
    endfunction

    task automatic drive_cycle(input int cyc);
        logic        r;
        logic        en;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          s;
        req_t        e;
        logic [31:0] rd_exp;
        logic        unm;

        if (cyc >= CYCLES) begin
            r = 1'b0; en = 1'b1; wen = 4'b0000; addr = 32'h8000_0000;
        end else begin
            r    = (cyc < 4) || ($urandom_range(0, 199) == 0);
            en   = ($urandom_range(0, 3) != 0);
            wen  = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
            addr = pick_addr();
        end
        wdata = $urandom;

        reset              = r;
        bif.cpu_data_en    = en;
        bif.cpu_data_wen   = wen;
        bif.cpu_data_addr  = addr;
        bif.cpu_data_wdata = wdata;

        s       = model_sel(addr);
        e.en    = '0;
        e.wen   = '0;
        e.addr  = addr;
        e.wdata = wdata;
        if (!r && s >= 0) begin
            e.en[s]        = en;
            e.wen[s*4 +: 4] = wen;
        end
        req_q.push_back(e);

        if (!r && en && wen == 4'b0000) rd_exp = (s >= 0) ? slave_data(s, addr) : UNMAPPED_RD;
        else rd_exp = 32'h0;
        if (r) begin
            foreach (rd_q[j]) rd_q[j] = 32'h0;
        end
        rd_q.push_back(rd_exp);

        unm = !r && en && (s < 0);
        if (r) begin
            m_cnt  = 0;
            m_addr = 32'h0;
        end else if (unm) begin
            m_addr = addr;
            if (m_cnt < 255) m_cnt++;
        end
        err_q.push_back('{unm, m_addr, 8'(m_cnt)});
    endtask

    initial begin
        req_t        e;
        logic [31:0] rd_exp;
        err_t        ee;
        forever begin
            @(negedge clk);
            if (running) begin
                if (req_q.size() == 0 || rd_q.size() == 0 || err_q.size() == 0) begin
                    chk("queue_underflow", 32'(req_q.size()), 32'd1);
                end else begin
                    e      = req_q.pop_front();
                    rd_exp = rd_q.pop_front();
                    ee     = err_q.pop_front();
                    chk("slv_en", 32'(slv_en), 32'(e.en));
                    chk("slv_wen", 32'(slv_wen), 32'(e.wen));
                    for (int i = 0; i < NS; i++) begin
                        chk("slv_addr", slv_addr[i*32 +: 32], e.addr);
                        chk("slv_wdata", slv_wdata[i*32 +: 32], e.wdata);
                    end
                    chk("cpu_data_rdata", bif.cpu_data_rdata, rd_exp);
`ifdef BRIDGE_DECERR_EN
                    chk("err_valid", 32'(err_valid), 32'(ee.valid));
                    chk("err_addr", err_addr, ee.addr);
                    chk("err_cnt", 32'(err_cnt), 32'(ee.cnt));
`endif
                end
            end
        end
    end

    initial begin
        reset              = 1'b1;
        bif.cpu_data_en    = 1'b0;
        bif.cpu_data_wen   = 4'b0000;
        bif.cpu_data_addr  = 32'h0;
        bif.cpu_data_wdata = 32'h0;
        repeat (L) rd_q.push_back(32'h0);
        err_q.push_back('{1'b0, 32'h0, 8'h00});

        for (int cyc = 0; cyc < CYCLES + DIRECT; cyc++) begin
            @(posedge clk);
            #1;
            drive_cycle(cyc);
            running = 1'b1;
        end
        @(posedge clk);
        #1;
        running = 1'b0;
`ifdef BRIDGE_DECERR_EN
        chk("err_cnt_saturated", 32'(err_cnt), 32'h0000_00ff);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
